// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS-I CPU: opcode/funct encodings, FSM states
// and the default reset vector.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one write port,
// $0 reads as zero, and a live tap of $2 for the harness.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] register_v0
);

    logic [31:0] regs [32];

    // Entry 0 is cleared on reset and never written, so it reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1         = regs[ra1];
    assign rd2         = regs[ra2];
    assign register_v0 = regs[2];

endmodule

// File: rtl/mips_cpu_avalon.sv
// Multicycle MIPS-I integer CPU with a single shared instruction/data Avalon-MM master.
// Define MIPS_HILO_EN to add HI/LO with MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
module mips_cpu_avalon #(
    parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    import mips_pkg::*;

    state_t state, state_nxt;

    logic [31:0] pc, npc;
    logic [31:0] ir, ir_pc, a_q, b_q, res_q;
    logic [4:0]  wr_dst_q;
    logic        wr_en_q, ld_q;

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd, shamt;
    logic [31:0] simm, zimm, pc4, br_off;
    logic signed [31:0] a_s, b_s, simm_s;

    assign op     = ir[31:26];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign simm   = sext16(ir[15:0]);
    assign zimm   = {16'h0000, ir[15:0]};
    assign simm_s = simm;
    assign a_s    = a_q;
    assign b_s    = b_q;
    assign pc4    = ir_pc + 32'd4;
    assign br_off = {simm[29:0], 2'b00};

    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;

    // Operands are read from the instruction word as it arrives on readdata in DECODE.
    mips_regfile u_regfile (
        .clk         (clk),
        .reset       (reset),
        .ra1         (readdata[25:21]),
        .ra2         (readdata[20:16]),
        .rd1         (rf_rd1),
        .rd2         (rf_rd2),
        .we          (rf_we),
        .wa          (wr_dst_q),
        .wd          (rf_wd),
        .register_v0 (register_v0)
    );

`ifdef MIPS_HILO_EN
    logic [31:0]        hi_q, lo_q;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s, rem_s;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'h0, a_q} * {32'h0, b_q};
    assign quot_s = (b_q != 32'd0) ? a_s / b_s : 32'sd0;
    assign rem_s  = (b_q != 32'd0) ? a_s % b_s : 32'sd0;

    always_ff @(posedge clk) begin
        if (state == EXEC && op == OP_SPECIAL) begin
            case (funct)
                F_MULT:  {hi_q, lo_q} <= prod_s;
                F_MULTU: {hi_q, lo_q} <= prod_u;
                F_DIV:   if (b_q != 32'd0) begin lo_q <= quot_s; hi_q <= rem_s; end
                F_DIVU:  if (b_q != 32'd0) begin lo_q <= a_q / b_q; hi_q <= a_q % b_q; end
                F_MTHI:  hi_q <= a_q;
                F_MTLO:  lo_q <= a_q;
                default: ;
            endcase
        end
    end
`endif

    logic [31:0] exec_res, br_tgt;
    logic [4:0]  exec_dst;
    logic        exec_wen, exec_mem, exec_ld, br_take;

    always_comb begin
        exec_res = '0;
        exec_dst = rd;
        exec_wen = 1'b0;
        exec_mem = 1'b0;
        exec_ld  = 1'b0;
        br_take  = 1'b0;
        br_tgt   = pc4 + br_off;
        case (op)
            OP_SPECIAL: begin
                exec_wen = 1'b1;
                case (funct)
                    F_SLL:  exec_res = b_q << shamt;
                    F_SRL:  exec_res = b_q >> shamt;
                    F_SRA:  exec_res = b_s >>> shamt;
                    F_SLLV: exec_res = b_q << a_q[4:0];
                    F_SRLV: exec_res = b_q >> a_q[4:0];
                    F_SRAV: exec_res = b_s >>> a_q[4:0];
                    F_ADDU: exec_res = a_q + b_q;
                    F_SUBU: exec_res = a_q - b_q;
                    F_AND:  exec_res = a_q & b_q;
                    F_OR:   exec_res = a_q | b_q;
                    F_XOR:  exec_res = a_q ^ b_q;
                    F_SLT:  exec_res = {31'b0, a_s < b_s};
                    F_SLTU: exec_res = {31'b0, a_q < b_q};
                    F_JR: begin
                        exec_wen = 1'b0;
                        br_take  = 1'b1;
                        br_tgt   = a_q;
                    end
                    F_JALR: begin
                        exec_res = ir_pc + 32'd8;
                        br_take  = 1'b1;
                        br_tgt   = a_q;
                    end
`ifdef MIPS_HILO_EN
                    F_MFHI: exec_res = hi_q;
                    F_MFLO: exec_res = lo_q;
                    F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: exec_wen = 1'b0;
`else
                    F_MFHI, F_MFLO, F_MTHI, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: exec_wen = 1'b0;
`endif
                    default: exec_wen = 1'b0;
                endcase
            end
            OP_J: begin
                br_take = 1'b1;
                br_tgt  = {pc4[31:28], ir[25:0], 2'b00};
            end
            OP_JAL: begin
                br_take  = 1'b1;
                br_tgt   = {pc4[31:28], ir[25:0], 2'b00};
                exec_res = ir_pc + 32'd8;
                exec_dst = 5'd31;
                exec_wen = 1'b1;
            end
            OP_BEQ: br_take = (a_q == b_q);
            OP_BNE: br_take = (a_q != b_q);
            OP_ADDIU: begin exec_res = a_q + simm;               exec_dst = rt; exec_wen = 1'b1; end
            OP_SLTI:  begin exec_res = {31'b0, a_s < simm_s};    exec_dst = rt; exec_wen = 1'b1; end
            OP_SLTIU: begin exec_res = {31'b0, a_q < simm};      exec_dst = rt; exec_wen = 1'b1; end
            OP_ANDI:  begin exec_res = a_q & zimm;               exec_dst = rt; exec_wen = 1'b1; end
            OP_ORI:   begin exec_res = a_q | zimm;               exec_dst = rt; exec_wen = 1'b1; end
            OP_XORI:  begin exec_res = a_q ^ zimm;               exec_dst = rt; exec_wen = 1'b1; end
            OP_LUI:   begin exec_res = {ir[15:0], 16'h0000};     exec_dst = rt; exec_wen = 1'b1; end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                exec_res = a_q + simm;
                exec_dst = rt;
                exec_wen = 1'b1;
                exec_mem = 1'b1;
                exec_ld  = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                exec_res = a_q + simm;
                exec_mem = 1'b1;
            end
            default: ;
        endcase
    end

    // Narrow loads pick their lane out of the returned word and extend it.
    function automatic logic [31:0] load_extract(input logic [5:0] opc, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (opc)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return {24'h000000, sh[7:0]};
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return {16'h0000, sh[15:0]};
            default: return word;
        endcase
    endfunction

    logic [3:0]  mem_be;
    logic [31:0] st_data;

    always_comb begin
        mem_be  = 4'hF;
        st_data = b_q;
        case (op)
            OP_LB, OP_LBU: mem_be = 4'b0001 << res_q[1:0];
            OP_LH, OP_LHU: mem_be = res_q[1] ? 4'b1100 : 4'b0011;
            OP_SB: begin
                mem_be  = 4'b0001 << res_q[1:0];
                st_data = {4{b_q[7:0]}};
            end
            OP_SH: begin
                mem_be  = res_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{b_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign rf_we = (state == WB) && wr_en_q;
    assign rf_wd = ld_q ? load_extract(op, res_q[1:0], readdata) : res_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    // Bus signals are decoded from state; reset forces the request off immediately.
    always_comb begin
        state_nxt  = state;
        active     = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = pc;
        byteenable = 4'h0;
        writedata  = '0;
        case (state)
            FETCH: begin
                if (pc == 32'd0) begin
                    state_nxt = HALT;
                end else begin
                    read       = 1'b1;
                    byteenable = 4'hF;
                    if (!waitrequest) state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = exec_mem ? MEM : WB;
            MEM: begin
                address    = {res_q[31:2], 2'b00};
                byteenable = mem_be;
                if (ld_q) begin
                    read = 1'b1;
                end else begin
                    write     = 1'b1;
                    writedata = st_data;
                end
                if (!waitrequest) state_nxt = WB;
            end
            WB:     state_nxt = FETCH;
            HALT:   active = 1'b0;
            default: state_nxt = FETCH;
        endcase
        if (!reset) begin
            read       = 1'b0;
            write      = 1'b0;
            byteenable = 4'h0;
            writedata  = '0;
        end
    end

    // npc runs one instruction ahead of pc, which gives the branch delay slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= RESET_VECTOR;
            npc <= RESET_VECTOR + 32'd4;
        end else if (state == DECODE) begin
            pc  <= npc;
            npc <= npc + 32'd4;
        end else if (state == EXEC && br_take) begin
            npc <= br_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            ir    <= readdata;
            ir_pc <= pc;
            a_q   <= rf_rd1;
            b_q   <= rf_rd2;
        end
        if (state == EXEC) begin
            res_q    <= exec_res;
            wr_dst_q <= exec_dst;
            wr_en_q  <= exec_wen;
            ld_q     <= exec_ld;
        end
    end

endmodule

// File: tb/tb_mips_cpu_avalon.sv
// Directed-program bench for mips_cpu_avalon: small hand-assembled programs run to halt
// against a word memory model, then $v0 and stored words are compared with hand-computed values.
module tb_mips_cpu_avalon;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'h0;

    always #5 clk = ~clk;

    mips_cpu_avalon dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic        load_img;
    int          wr_cnt;
    logic [3:0]  first_wbe;
    logic [31:0] first_wd;
    logic [3:0]  last_dbe;

    int n_checks;
    int n_errors;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a[31:10] == 22'h2FF000) return mem[a[9:2]];
        return 32'h0;
    endfunction

    // Memory window 0xBFC00000..0xBFC003FF; lane i is byte address+i.
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            wr_cnt <= 0;
        end else begin
            if (read && !waitrequest) begin
                readdata <= rd_word(address);
                if (address >= 32'hBFC00100) last_dbe <= byteenable;
            end
            if (write && !waitrequest) begin
                if (address[31:10] == 22'h2FF000)
                    for (int l = 0; l < 4; l++)
                        if (byteenable[l]) mem[address[9:2]][8*l +: 8] <= writedata[8*l +: 8];
                if (wr_cnt == 0) begin
                    first_wbe <= byteenable;
                    first_wd  <= writedata;
                end
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sa);
        return {6'h00, rs, rt, rd, sa, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    localparam logic [31:0] JR0 = 32'h00000008;

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    // $1 = 0xBFC00100; data word there holds bytes 00 81 01 80 at offsets 0..3.
    task automatic base_setup();
        clear_img();
        img[0]  = enc_i(6'h0F, 5'd0, 5'd1, 16'hBFC0);
        img[1]  = enc_i(6'h0D, 5'd1, 5'd1, 16'h0100);
        img[64] = 32'h80018100;
    endtask

    task automatic start(input logic stall);
        reset       = 1'b0;
        waitrequest = stall;
        load_img    = 1'b1;
        @(negedge clk);
        load_img    = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
    endtask

    task automatic run(input string tag);
        int cyc;
        cyc = 0;
        while (active === 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_halted"}, {31'b0, active}, 32'h0);
    endtask

    task automatic load_test(input string tag, input logic [31:0] ins,
                             input logic [31:0] exp_v0, input logic [3:0] exp_be);
        base_setup();
        img[2] = ins;
        img[3] = JR0;
        img[4] = 32'h0;
        start(1'b0);
        run(tag);
        check({tag, "_v0"}, register_v0, exp_v0);
        check({tag, "_be"}, {28'h0, last_dbe}, {28'h0, exp_be});
    endtask

    logic [31:0] alu_ins [21];
    logic [31:0] alu_exp [21];

    // $3 = 0xFFFFFFF8 (-8), $4 = 13; every result lands in $5.
    task automatic fill_alu();
        alu_ins[0]  = enc_r(6'h21, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[0]  = 32'h00000005;
        alu_ins[1]  = enc_r(6'h23, 5'd4, 5'd3, 5'd5, 5'd0);  alu_exp[1]  = 32'h00000015;
        alu_ins[2]  = enc_r(6'h24, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[2]  = 32'h00000008;
        alu_ins[3]  = enc_r(6'h25, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[3]  = 32'hFFFFFFFD;
        alu_ins[4]  = enc_r(6'h26, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[4]  = 32'hFFFFFFF5;
        alu_ins[5]  = enc_r(6'h2A, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[5]  = 32'h00000001;
        alu_ins[6]  = enc_r(6'h2B, 5'd3, 5'd4, 5'd5, 5'd0);  alu_exp[6]  = 32'h00000000;
        alu_ins[7]  = enc_r(6'h03, 5'd0, 5'd3, 5'd5, 5'd2);  alu_exp[7]  = 32'hFFFFFFFE;
        alu_ins[8]  = enc_r(6'h02, 5'd0, 5'd3, 5'd5, 5'd4);  alu_exp[8]  = 32'h0FFFFFFF;
        alu_ins[9]  = enc_r(6'h00, 5'd0, 5'd4, 5'd5, 5'd28); alu_exp[9]  = 32'hD0000000;
        alu_ins[10] = enc_r(6'h04, 5'd4, 5'd3, 5'd5, 5'd0);  alu_exp[10] = 32'hFFFF0000;
        alu_ins[11] = enc_r(6'h06, 5'd4, 5'd3, 5'd5, 5'd0);  alu_exp[11] = 32'h0007FFFF;
        alu_ins[12] = enc_r(6'h07, 5'd4, 5'd3, 5'd5, 5'd0);  alu_exp[12] = 32'hFFFFFFFF;
        alu_ins[13] = enc_i(6'h0C, 5'd3, 5'd5, 16'hF0F0);    alu_exp[13] = 32'h0000F0F0;
        alu_ins[14] = enc_i(6'h0E, 5'd3, 5'd5, 16'h8000);    alu_exp[14] = 32'hFFFF7FF8;
        alu_ins[15] = enc_i(6'h0A, 5'd3, 5'd5, 16'hFFF9);    alu_exp[15] = 32'h00000001;
        alu_ins[16] = enc_i(6'h0B, 5'd4, 5'd5, 16'hFFFF);    alu_exp[16] = 32'h00000001;
        alu_ins[17] = enc_i(6'h09, 5'd4, 5'd5, 16'hFFEC);    alu_exp[17] = 32'hFFFFFFF9;
        alu_ins[18] = enc_i(6'h0F, 5'd0, 5'd5, 16'h1234);    alu_exp[18] = 32'h12340000;
        alu_ins[19] = enc_i(6'h0D, 5'd4, 5'd5, 16'h8000);    alu_exp[19] = 32'h0000800D;
        alu_ins[20] = enc_r(6'h21, 5'd0, 5'd0, 5'd5, 5'd0);  alu_exp[20] = 32'h00000000;
    endtask

    initial begin
        int cyc;
        logic found;
        n_checks = 0;
        n_errors = 0;
        reset       = 1'b0;
        waitrequest = 1'b0;
        load_img    = 1'b0;

        // Reset state
        clear_img();
        start(1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_active", {31'b0, active}, 32'h1);
        check("rst_read",   {31'b0, read},   32'h0);
        check("rst_write",  {31'b0, write},  32'h0);
        check("rst_be",     {28'h0, byteenable}, 32'h0);
        check("rst_wd",     writedata,   32'h0);
        check("rst_v0",     register_v0, 32'h0);

        // Narrow loads from bytes 00 81 01 80
        load_test("lb",  enc_i(6'h20, 5'd1, 5'd2, 16'h0001), 32'hFFFFFF81, 4'b0010);
        check("halt_read",  {31'b0, read},  32'h0);
        check("halt_write", {31'b0, write}, 32'h0);
        repeat (5) @(negedge clk);
        check("halt_frozen_active", {31'b0, active}, 32'h0);
        check("halt_frozen_v0", register_v0, 32'hFFFFFF81);
        load_test("lbu", enc_i(6'h24, 5'd1, 5'd2, 16'h0001), 32'h00000081, 4'b0010);
        load_test("lh",  enc_i(6'h21, 5'd1, 5'd2, 16'h0002), 32'hFFFF8001, 4'b1100);
        load_test("lhu", enc_i(6'h25, 5'd1, 5'd2, 16'h0002), 32'h00008001, 4'b1100);
        load_test("lw",  enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 32'h80018100, 4'b1111);

        // Stall: first fetch held for three cycles
        base_setup();
        img[2] = enc_i(6'h20, 5'd1, 5'd2, 16'h0001);
        img[3] = JR0;
        start(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_read", {31'b0, read}, 32'h1);
            check("stall_addr", address, 32'hBFC00000);
        end
        waitrequest = 1'b0;
        run("stall");
        check("stall_v0", register_v0, 32'hFFFFFF81);

        // SB then SW then LW
        base_setup();
        img[64] = 32'h0;
        img[2]  = enc_i(6'h09, 5'd0, 5'd3, 16'h00AB);
        img[3]  = enc_i(6'h0F, 5'd0, 5'd4, 16'h1234);
        img[4]  = enc_i(6'h0D, 5'd4, 5'd4, 16'h5678);
        img[5]  = enc_i(6'h28, 5'd1, 5'd3, 16'h0002);
        img[6]  = enc_i(6'h2B, 5'd1, 5'd4, 16'h0004);
        img[7]  = enc_i(6'h23, 5'd1, 5'd2, 16'h0004);
        img[8]  = JR0;
        start(1'b0);
        run("sbsw");
        check("sbsw_v0",    register_v0, 32'h12345678);
        check("sb_be",      {28'h0, first_wbe}, 32'h4);
        check("sb_wd",      first_wd, 32'hABABABAB);
        check("sb_mem",     mem[64], 32'h00AB0000);
        check("sw_mem",     mem[65], 32'h12345678);

        // Reset while fetching the JR at 0xBFC00020, then rerun from the vector
        start(1'b0);
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (read && address == 32'hBFC00020) found = 1'b1;
        end
        check("midrst_reached", {31'b0, found}, 32'h1);
        check("midrst_v0_before", register_v0, 32'h12345678);
        reset = 1'b0;
        #1;
        check("midrst_read",   {31'b0, read},  32'h0);
        check("midrst_write",  {31'b0, write}, 32'h0);
        check("midrst_be",     {28'h0, byteenable}, 32'h0);
        check("midrst_active", {31'b0, active}, 32'h1);
        check("midrst_v0",     register_v0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("refetch_read", {31'b0, read}, 32'h1);
        check("refetch_addr", address, 32'hBFC00000);
        run("rerun");
        check("rerun_v0", register_v0, 32'h12345678);

        // Delay slots: taken BEQ and not-taken BNE
        clear_img();
        img[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0000);
        img[1]  = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);
        img[2]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
        img[3]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0064);
        img[4]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0002);
        img[5]  = enc_i(6'h05, 5'd0, 5'd0, 16'h0003);
        img[6]  = 32'h0;
        img[7]  = JR0;
        img[8]  = 32'h0;
        img[9]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0032);
        img[10] = JR0;
        start(1'b0);
        run("branch");
        check("branch_v0", register_v0, 32'h00000003);

        // JAL into a subroutine that sets $2 = 5, JR $31 back
        clear_img();
        img[0] = enc_j(6'h03, 32'hBFC00018);
        img[2] = JR0;
        img[6] = enc_i(6'h09, 5'd0, 5'd2, 16'h0005);
        img[7] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        start(1'b0);
        run("jal");
        check("jal_v0", register_v0, 32'h00000005);

        // Link value visible after return: $2 = $31
        clear_img();
        img[0] = enc_j(6'h03, 32'hBFC00018);
        img[2] = enc_r(6'h21, 5'd31, 5'd0, 5'd2, 5'd0);
        img[3] = JR0;
        img[6] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        start(1'b0);
        run("link");
        check("link_v0", register_v0, 32'hBFC00008);

        // JALR links into $2
        clear_img();
        img[0] = enc_i(6'h0F, 5'd0, 5'd7, 16'hBFC0);
        img[1] = enc_i(6'h0D, 5'd7, 5'd7, 16'h0018);
        img[2] = enc_r(6'h09, 5'd7, 5'd0, 5'd2, 5'd0);
        img[6] = JR0;
        start(1'b0);
        run("jalr");
        check("jalr_v0", register_v0, 32'hBFC00010);

        // ALU table: each result stored to 0xBFC00100 + 4k
        fill_alu();
        clear_img();
        img[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'hBFC0);
        img[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'h0100);
        img[2] = enc_i(6'h09, 5'd0, 5'd3, 16'hFFF8);
        img[3] = enc_i(6'h09, 5'd0, 5'd4, 16'h000D);
        img[4] = enc_i(6'h09, 5'd0, 5'd0, 16'h0007);
        for (int k = 0; k < 21; k++) begin
            logic [15:0] off;
            off = 16'(4 * k);
            img[5 + 2*k] = alu_ins[k];
            img[6 + 2*k] = enc_i(6'h2B, 5'd1, 5'd5, off);
        end
        img[47] = JR0;
        for (int k = 0; k < 21; k++) img[64 + k] = 32'hDEADBEEF;
        start(1'b0);
        run("alu");
        for (int k = 0; k < 21; k++) check($sformatf("alu%0d", k), mem[64 + k], alu_exp[k]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
